// File: rtl/rv_exec_mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package rv_exec_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  localparam int BPC_RADIX2  = 1;
  localparam int BPC_RADIX4  = 2;
  localparam int BPC_RADIX16 = 4;

  function automatic logic op1_signed(mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(mdu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/rv_exec_mdu_div_step.sv
// One radix-2^K restoring division step: shifts K dividend bits into the
// partial remainder and produces K quotient bits.
module rv_mdu_div_step #(
  parameter int XLEN = 32,
  parameter int K    = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [K-1:0]    dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [K-1:0]    quo_o
);

  logic [XLEN:0] r;

  // rem_i < dvs_i (or dvs_i == 0) keeps the shifted remainder within XLEN+1 bits
  always_comb begin
    r     = {1'b0, rem_i};
    quo_o = '0;
    for (int i = K - 1; i >= 0; i--) begin
      r = {r[XLEN-1:0], dvd_i[i]};
      if (r >= {1'b0, dvs_i}) begin
        r        = r - {1'b0, dvs_i};
        quo_o[i] = 1'b1;
      end
    end
    rem_o = r[XLEN-1:0];
  end

endmodule

// File: rtl/rv_exec_mdu.sv
// Iterative RV32M multiply/divide unit: sign-magnitude shift-add multiply and
// restoring divide, K bits per cycle, one-cycle registered result strobe.
module rv_exec_mdu
  import rv_exec_mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int FAST_SPECIAL   = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = XLEN / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  mdu_op_t           op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              negp_q, negp_d, negr_q, negr_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rdo_q, rdo_d;

  // accept-side decode
  mdu_op_t         op_in;
  logic            neg1, neg2, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  assign op_in    = mdu_op_t'(i_funct3);
  assign neg1     = op1_signed(op_in) & i_op1[XLEN-1];
  assign neg2     = op2_signed(op_in) & i_op2[XLEN-1];
  assign mag1     = neg1 ? -i_op1 : i_op1;
  assign mag2     = neg2 ? -i_op2 : i_op2;
  assign div_zero = i_funct3[2] & (i_op2 == '0);
  assign div_ovf  = i_funct3[2] & ~i_funct3[0] & (i_op1 == XMIN) & (i_op2 == '1);
  assign special  = (FAST_SPECIAL != 0) & (div_zero | div_ovf);
  assign spec_res = div_zero ? (i_funct3[1] ? i_op1 : '1)
                             : (i_funct3[1] ? '0 : XMIN);
  assign accept   = i_valid & o_ready & ~i_flush;

  // iteration datapath; acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN+K-1:0] mul_hi;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, step_acc, prod;
  logic [XLEN-1:0]   div_rem, quo_s, rem_s, fin_res;
  logic [K-1:0]      div_quo;

  assign mul_hi = {{K{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                + ({{K{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[K-1:0]});
  assign mul_nxt = {mul_hi, acc_q[XLEN-1:K]};

  rv_mdu_div_step #(.XLEN(XLEN), .K(K)) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .dvd_i (acc_q[XLEN-1:XLEN-K]),
    .dvs_i (opb_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  assign div_nxt  = {div_rem, acc_q[XLEN-K-1:0], div_quo};
  assign step_acc = op_q[2] ? div_nxt : mul_nxt;

  assign prod    = negp_q ? -step_acc : step_acc;
  assign quo_s   = negp_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
  assign rem_s   = negr_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
  assign fin_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                           : ((op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op_in;
          rd_d   = i_rd;
          acc_d  = {{XLEN{1'b0}}, mag1};
          opb_d  = mag2;
          // divide-by-zero keeps the all-ones quotient unsigned
          negp_d = (neg1 ^ neg2) & ~div_zero;
          negr_d = neg1;
          cnt_d  = '0;
          if (special) begin
            state_d = ST_DONE;
            res_d   = spec_res;
            rdo_d   = i_rd;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST && !i_flush) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          res_d   = fin_res;
          rdo_d   = rd_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = res_q;
  assign o_rd     = rdo_q;

endmodule

// File: tb/tb_rv_exec_mdu.sv
// Scoreboard bench: four configurations of the MDU share one stimulus stream;
// each has its own monitor walking the shared expectation queue.
module tb_rv_exec_mdu;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  f3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] a = '0, b = '0;

  logic [NDUT-1:0] rdy, busy, vld;
  logic [31:0]     res [NDUT];
  logic [4:0]      rdo [NDUT];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rv_exec_mdu #(.XLEN(32), .BITS_PER_CYCLE(1), .FAST_SPECIAL(1)) u_b1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy[0]),
    .i_funct3(f3), .i_rd(rd), .i_op1(a), .i_op2(b), .o_busy(busy[0]), .o_valid(vld[0]),
    .o_result(res[0]), .o_rd(rdo[0]));
  rv_exec_mdu #(.XLEN(32), .BITS_PER_CYCLE(2), .FAST_SPECIAL(1)) u_b2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy[1]),
    .i_funct3(f3), .i_rd(rd), .i_op1(a), .i_op2(b), .o_busy(busy[1]), .o_valid(vld[1]),
    .o_result(res[1]), .o_rd(rdo[1]));
  rv_exec_mdu #(.XLEN(32), .BITS_PER_CYCLE(4), .FAST_SPECIAL(1)) u_b4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy[2]),
    .i_funct3(f3), .i_rd(rd), .i_op1(a), .i_op2(b), .o_busy(busy[2]), .o_valid(vld[2]),
    .o_result(res[2]), .o_rd(rdo[2]));
  rv_exec_mdu #(.XLEN(32), .BITS_PER_CYCLE(1), .FAST_SPECIAL(0)) u_slow (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy[3]),
    .i_funct3(f3), .i_rd(rd), .i_op1(a), .i_op2(b), .o_busy(busy[3]), .o_valid(vld[3]),
    .o_result(res[3]), .o_rd(rdo[3]));

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    bit          sp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   rd_idx [NDUT] = '{default: 0};
  int   checks = 0;
  int   fails  = 0;
  int   rdn    = 1;

  // cycles from the issue cycle to the strobe cycle
  function automatic int lat_of(int i, bit sp);
    int bpc;
    bpc = (i == 1) ? 2 : (i == 2) ? 4 : 1;
    return (sp && i != 3) ? 1 : 32 / bpc + 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        if (vld[i]) begin
          if (rd_idx[i] >= sb.size()) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid dut%0d: got strobe with result %h expected none", i, res[i]);
          end else begin
            e = sb[rd_idx[i]];
            rd_idx[i]++;
            chk($sformatf("%s.dut%0d.result", e.nm, i), res[i], e.res);
            chk($sformatf("%s.dut%0d.rd", e.nm, i), {27'b0, rdo[i]}, {27'b0, e.rd});
            chk($sformatf("%s.dut%0d.latency", e.nm, i), 32'(cyc - e.cyc), 32'(lat_of(i, e.sp)));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (rdy !== '1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: ready %b expected 1111", rdy);
    end
  endtask

  task automatic issue(string nm, logic [2:0] fn, logic [31:0] x, logic [31:0] y,
                       logic [31:0] ex, bit sp, bit push);
    exp_t t;
    wait_idle();
    f3 = fn; rd = 5'(rdn); a = x; b = y; valid = 1'b1;
    if (push) begin
      t.nm = nm; t.res = ex; t.rd = 5'(rdn); t.cyc = cyc; t.sp = sp;
      sb.push_back(t);
    end
    rdn = (rdn % 31) + 1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic chk_idle_all(string nm);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("%s.dut%0d.vld_busy_rdy", nm, i),
          32'({vld[i], busy[i], rdy[i]}), 32'b001);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle_all("reset");
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset.dut%0d.result", i), res[i], 32'h0);
      chk($sformatf("reset.dut%0d.rd", i), {27'b0, rdo[i]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    issue("mul_7xm3",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1);
    issue("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1);
    issue("mulhu_min",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1);
    issue("mulhsu_min", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 0, 1);
    issue("mul_shift",  3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0, 1);
    issue("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, 1);
    issue("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1);
    issue("divu_big_2", 3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0, 1);
    issue("div_100_m7", 3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 1);
    issue("rem_100_m7", 3'b110, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 0, 1);
    issue("remu_100_7", 3'b111, 32'd100,       32'd7,         32'h0000_0002, 0, 1);
    issue("div_x_0",    3'b100, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1, 1);
    issue("rem_x_0",    3'b110, 32'h1234_5678, 32'h0,         32'h1234_5678, 1, 1);
    issue("div_neg_0",  3'b100, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 1, 1);
    issue("rem_neg_0",  3'b110, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1, 1);
    issue("divu_5_0",   3'b101, 32'd5,         32'h0,         32'hFFFF_FFFF, 1, 1);
    issue("remu_5_0",   3'b111, 32'd5,         32'h0,         32'h0000_0005, 1, 1);
    issue("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
    issue("divu_min_1s",3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1);
    issue("remu_min_1s",3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);

    // flush mid-iteration: every configuration is still iterating here
    issue("flushed_div", 3'b100, 32'd1000, 32'd3, 32'h0, 0, 0);
    repeat (4) @(negedge clk);
    chk("flush.pre_busy", 32'(busy), 32'hF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_idle_all("flush_calc");
    repeat (40) @(negedge clk);

    // flush beats a same-cycle request
    f3 = 3'b000; a = 32'd3; b = 32'd4; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    chk_idle_all("flush_accept");
    repeat (40) @(negedge clk);

    // asynchronous reset in the middle of an operation
    issue("reset_div", 3'b100, 32'd1000, 32'd7, 32'h0, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_all("async_reset");
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("async_reset.dut%0d.result", i), res[i], 32'h0);
      chk($sformatf("async_reset.dut%0d.rd", i), {27'b0, rdo[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("drain.dut%0d.strobes", i), 32'(rd_idx[i]), 32'(sb.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
